// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer_if
//  Purpose  : Bundles the request, mux-side and result signals of the ALU
//             operation sequencer.
//  Ports    : op_in/op_valid/op_ready  - single-operation request handshake
//             auto_en                  - scan-mode level
//             res_bit                  - mux output O for the current alu_sel
//             alu_sel/sel_valid        - select driven to the mux S input
//             res_out/res_valid/res_vec- captured results
//             scan_done/err            - status pulses
//  Modports : master - board / stimulus side
//             slave  - sequencer side
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if;
    logic [3:0]  op_in;
    logic        op_valid;
    logic        op_ready;
    logic        auto_en;
    logic        res_bit;
    logic [3:0]  alu_sel;
    logic        sel_valid;
    logic        res_out;
    logic        res_valid;
    logic [12:0] res_vec;
    logic        scan_done;
    logic        err;

    modport master (
        output op_in, op_valid, auto_en, res_bit,
        input  op_ready, alu_sel, sel_valid, res_out, res_valid, res_vec,
               scan_done, err
    );

    modport slave (
        input  op_in, op_valid, auto_en, res_bit,
        output op_ready, alu_sel, sel_valid, res_out, res_valid, res_vec,
               scan_done, err
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Drives the 4-bit operation select of the ALU result mux, waits
//             one settle cycle, then captures the mux's 1-bit output. Runs a
//             single requested operation (valid/ready) or auto-scans ops
//             0..12 holding each result for DWELL_CYCLES cycles.
//  Ports    : clk   - system clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - alu_op_sequencer_if.slave (request, mux, result signals)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int unsigned DWELL_CYCLES = 50000000,
    parameter int unsigned CNT_W        = 26
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_op_sequencer_if.slave  bus
);

    localparam logic [3:0]       LAST_OP    = 4'd12;
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [3:0]        alu_sel_q,   alu_sel_d;
    logic              scan_q,      scan_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              res_out_q,   res_out_d;
    logic              res_valid_q, res_valid_d;
    logic [12:0]       res_vec_q,   res_vec_d;
    logic              scan_done_q, scan_done_d;
    logic              err_q,       err_d;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_sel_q   <= 4'd0;
            scan_q      <= 1'b0;
            cnt_q       <= '0;
            res_out_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_vec_q   <= 13'd0;
            scan_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_sel_q   <= alu_sel_d;
            scan_q      <= scan_d;
            cnt_q       <= cnt_d;
            res_out_q   <= res_out_d;
            res_valid_q <= res_valid_d;
            res_vec_q   <= res_vec_d;
            scan_done_q <= scan_done_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        alu_sel_d   = alu_sel_q;
        scan_d      = scan_q;
        cnt_d       = cnt_q;
        res_out_d   = res_out_q;
        res_vec_d   = res_vec_q;
        res_valid_d = 1'b0;
        scan_done_d = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Scan mode outranks any concurrent single-op request.
                if (bus.auto_en) begin
                    alu_sel_d = 4'd0;
                    scan_d    = 1'b1;
                    state_d   = ST_SETTLE;
                end else if (bus.op_valid) begin
                    if (bus.op_in <= LAST_OP) begin
                        alu_sel_d = bus.op_in;
                        scan_d    = 1'b0;
                        state_d   = ST_SETTLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_SETTLE: begin
                // The mux has had one full cycle to settle on alu_sel_q.
                res_out_d   = bus.res_bit;
                res_valid_d = 1'b1;
                for (int i = 0; i < 13; i++) begin
                    if (alu_sel_q == 4'(i)) begin
                        res_vec_d[i] = bus.res_bit;
                    end
                end
                scan_done_d = scan_q && (alu_sel_q == LAST_OP);
                if (scan_q) begin
                    cnt_d   = DWELL_LOAD;
                    state_d = ST_DWELL;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DWELL: begin
                if (!bus.auto_en) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    alu_sel_d = (alu_sel_q == LAST_OP) ? 4'd0 : alu_sel_q + 4'd1;
                    state_d   = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.op_ready  = (state_q == ST_IDLE) && !bus.auto_en;
    assign bus.sel_valid = (state_q == ST_SETTLE);
    assign bus.alu_sel   = alu_sel_q;
    assign bus.res_out   = res_out_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_vec   = res_vec_q;
    assign bus.scan_done = scan_done_q;
    assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Purpose  : Directed self-checking bench for alu_op_sequencer with a
//             scoreboard of expected captures (DWELL_CYCLES = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int DWELL = 4;

    logic clk;
    logic rst_n;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(
        .DWELL_CYCLES (DWELL),
        .CNT_W        (3)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic       rbit;
        logic       done;
        logic       scan;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_rv  = 0;
    logic prev_scan = 1'b0;
    int   done_cnt = 0;

    // Mux model: either a forced bit or the LSB of the select.
    logic use_lsb;
    logic forced_bit;
    always_comb bus.res_bit = use_lsb ? bus.alu_sel[0] : forced_bit;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q_empty(input string tag, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: every res_valid pulse pops and checks one expected capture.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (bus.res_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_res_valid", bus.res_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_out", bus.res_out, e.rbit);
                    chk("res_sel", bus.alu_sel, e.sel);
                    chk("scan_done", bus.scan_done, e.done);
                    if (e.done) chk("res_vec_pass", bus.res_vec, 13'h0AAA);
                    if (e.scan && prev_scan) chk("scan_period", cyc - last_rv, DWELL + 1);
                    prev_scan = e.scan;
                    last_rv   = cyc;
                end
            end else if (bus.scan_done === 1'b1) begin
                chk("scan_done_no_rv", bus.scan_done, 0);
            end
            if (bus.scan_done === 1'b1) done_cnt++;
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.op_in    = 4'd0;
        bus.op_valid = 1'b0;
        bus.auto_en  = 1'b0;
        use_lsb      = 1'b0;
        forced_bit   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_alu_sel",   bus.alu_sel,   0);
        chk("rst_res_vec",   bus.res_vec,   0);
        chk("rst_res_out",   bus.res_out,   0);
        chk("rst_sel_valid", bus.sel_valid, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_scan_done", bus.scan_done, 0);
        chk("rst_err",       bus.err,       0);
        chk("rst_op_ready",  bus.op_ready,  1);
        tick();
        rst_n = 1'b1;
        tick();

        // Single op 5 with result 1.
        bus.op_in    = 4'd5;
        bus.op_valid = 1'b1;
        forced_bit   = 1'b1;
        exp_q.push_back('{sel: 4'd5, rbit: 1'b1, done: 1'b0, scan: 1'b0});
        tick();
        bus.op_valid = 1'b0;
        @(negedge clk);
        chk("op5_alu_sel",   bus.alu_sel,   5);
        chk("op5_sel_valid", bus.sel_valid, 1);
        chk("op5_op_ready",  bus.op_ready,  0);
        chk("op5_early_rv",  bus.res_valid, 0);
        tick();
        @(negedge clk);
        chk("op5_res_valid", bus.res_valid, 1);
        chk("op5_sel_valid_off", bus.sel_valid, 0);
        chk("op5_op_ready_back", bus.op_ready, 1);
        chk("op5_res_vec",   bus.res_vec,   13'h0020);
        tick();
        @(negedge clk);
        chk("op5_rv_pulse",  bus.res_valid, 0);
        wait_q_empty("op5_drained", 4);

        // Illegal op 14.
        tick();
        bus.op_in    = 4'd14;
        bus.op_valid = 1'b1;
        tick();
        bus.op_valid = 1'b0;
        @(negedge clk);
        chk("err_pulse",     bus.err,       1);
        chk("err_alu_sel",   bus.alu_sel,   5);
        chk("err_res_vec",   bus.res_vec,   13'h0020);
        chk("err_op_ready",  bus.op_ready,  1);
        chk("err_sel_valid", bus.sel_valid, 0);
        tick();
        @(negedge clk);
        chk("err_one_cycle", bus.err,       0);
        repeat (3) tick();

        // Scan with concurrent op request; auto_en must win.
        use_lsb      = 1'b1;
        bus.auto_en  = 1'b1;
        bus.op_valid = 1'b1;
        bus.op_in    = 4'd3;
        for (int i = 0; i <= 13; i++) begin
            exp_q.push_back('{sel: 4'(i % 13), rbit: 1'((i % 13) & 1),
                              done: (i == 12), scan: 1'b1});
        end
        @(negedge clk);
        chk("scan_op_ready", bus.op_ready, 0);
        tick();
        bus.op_valid = 1'b0;
        @(negedge clk);
        chk("scan_start_sel",   bus.alu_sel,   0);
        chk("scan_start_settle", bus.sel_valid, 1);
        wait_q_empty("scan_pass", 200);
        chk("scan_done_count", done_cnt, 1);
        chk("scan_wrap_sel",   bus.alu_sel, 0);

        // Continue to op 7, then drop auto_en during its dwell.
        for (int i = 1; i <= 7; i++) begin
            exp_q.push_back('{sel: 4'(i), rbit: 1'(i & 1), done: 1'b0, scan: 1'b1});
        end
        wait_q_empty("scan_to_7", 100);
        tick();
        bus.auto_en = 1'b0;
        tick();
        @(negedge clk);
        chk("drop_op_ready",  bus.op_ready,  1);
        chk("drop_alu_sel",   bus.alu_sel,   7);
        chk("drop_sel_valid", bus.sel_valid, 0);
        repeat (12) tick();
        @(negedge clk);
        chk("drop_alu_hold",  bus.alu_sel,   7);
        chk("drop_done_cnt",  done_cnt,      1);

        // Reset asserted while in SETTLE.
        tick();
        use_lsb      = 1'b0;
        forced_bit   = 1'b1;
        bus.op_in    = 4'd2;
        bus.op_valid = 1'b1;
        tick();
        bus.op_valid = 1'b0;
        chk("rs_in_settle", bus.sel_valid, 1);
        chk("rs_sel",       bus.alu_sel,   2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_sel_valid", bus.sel_valid, 0);
        chk("rs_alu_sel",   bus.alu_sel,   0);
        chk("rs_res_vec",   bus.res_vec,   0);
        chk("rs_res_out",   bus.res_out,   0);
        chk("rs_res_valid", bus.res_valid, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("rs_after_vec",  bus.res_vec,  0);
        chk("rs_after_ready", bus.op_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control-side counterpart of the ALU result multiplexer.
- Issues the 4-bit operation select to the mux, waits one settle cycle, then captures the mux's 1-bit output.
- Runs a single requested operation via a valid/ready handshake, or auto-scans all 13 operations (0..12) with a programmable dwell.
- Sits between the board input logic (switches/buttons) and the ALU mux select/output pins.

Parameters:
- DWELL_CYCLES, 50000000, clock cycles each scan result is held before advancing (≥1).
- CNT_W, 26, width of the dwell counter; must hold DWELL_CYCLES-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_in  in  4  requested operation code.
- op_valid  in  1  request strobe for op_in.
- op_ready  out  1  high when a single-op request can be accepted.
- auto_en  in  1  level; high selects scan mode.
- res_bit  in  1  mux output O for the current alu_sel.
- alu_sel  out  4  select driven to the mux S input.
- sel_valid  out  1  alu_sel is stable and being evaluated.
- res_out  out  1  last captured result.
- res_valid  out  1  one-cycle pulse when res_out is updated.
- res_vec  out  13  per-op captured results; bit i = result of op i.
- scan_done  out  1  one-cycle pulse when op 12 is captured in scan mode.
- err  out  1  one-cycle pulse on an illegal op request.

Behaviour:
- Reset, asynchronous and effective mid-operation:
  - state=IDLE, alu_sel=0, res_out=0, res_vec=0, dwell counter=0.
  - sel_valid, res_valid, scan_done and err are all 0.
- States: IDLE, SETTLE, DWELL. Mode flag `scan` is set in IDLE on scan entry.
- op_ready = (state==IDLE) && !auto_en. It is combinational from registered state.
- IDLE transitions:
  - auto_en=1: alu_sel<=0, scan<=1, go SETTLE. Any concurrent op_valid is ignored; auto_en has priority.
  - Else op_valid=1 and op_in≤12: alu_sel<=op_in, scan<=0, go SETTLE.
  - Else op_valid=1 and op_in in 13..15: err=1 for the next cycle, alu_sel unchanged, stay IDLE.
- SETTLE lasts exactly 1 cycle with sel_valid=1. On the exiting edge:
  - res_out<=res_bit and res_vec[alu_sel]<=res_bit.
  - res_valid=1 for the following cycle.
  - scan=1 and alu_sel==12: scan_done=1 for that same cycle.
  - Next state is DWELL (counter<=DWELL_CYCLES-1) if scan, else IDLE.
- Latency: request accepted on edge N → res_valid high in the cycle after edge N+1.
- sel_valid is 1 only in SETTLE. alu_sel holds its value in IDLE and DWELL.
- DWELL:
  - Counter decrements each cycle.
  - auto_en=0 at any point: go IDLE immediately, counter cleared, alu_sel held.
  - Counter==0 and auto_en=1: alu_sel <= (alu_sel==12) ? 0 : alu_sel+1, go SETTLE.
- Wrap-around: after 12 the scan returns to 0. res_vec keeps old bits until each is overwritten.
- DWELL_CYCLES=1: DWELL lasts one cycle, so the scan period is 2 cycles per op.
- Single-op mode never asserts scan_done.
- Consecutive single requests: op_ready returns high in the cycle res_valid is asserted, so the next request is accepted on the next edge.

Test Plan:
- Reset, then op_in=5 with op_valid 1 cycle and res_bit=1 → alu_sel=5 and sel_valid=1 for 1 cycle; res_valid pulse 2 cycles after accept; res_out=1, res_vec=13'h0020.
- op_in=14 with op_valid → err pulse of 1 cycle, alu_sel/res_vec unchanged, op_ready stays 1.
- DWELL_CYCLES=4, auto_en=1, res_bit=alu_sel[0] → alu_sel steps 0..12 every 5 cycles; scan_done pulses once per pass; res_vec=13'h0AAA; 13th step wraps to alu_sel=0.
- auto_en=1 and op_valid=1 (op_in=3) in the same cycle → scan starts at alu_sel=0, op not accepted, op_ready=0.
- auto_en dropped mid-DWELL at alu_sel=7 → IDLE next cycle, alu_sel holds 7, no further res_valid, op_ready=1.
- rst_n asserted during SETTLE → all outputs 0 immediately, before the next clock edge; no res_valid after release.
